// File: rtl/photonic_cmd_pkg.sv
// photonic_cmd_pkg: shared framing constants, decoder state encoding and byte-count sizing
package photonic_cmd_pkg;
  localparam logic [7:0] SYNC_BYTE  = 8'hA5;
  localparam logic [7:0] ABORT_BYTE = 8'h5A;
  typedef enum logic [2:0] {IDLE, CMD, DATA, CHK, LOAD, RUN} state_t;
  function automatic int cnt_bits(input int width);
    return (width / 8 > 1) ? $clog2(width / 8) : 1;
  endfunction
endpackage

// File: rtl/photonic_cmd_decoder_if.sv
// photonic_cmd_decoder_if: UART byte input, counter feedback and counter control/status bundle
interface photonic_cmd_decoder_if #(
  parameter int WIDTH   = 16,
  parameter int CH_BITS = 2
);
  logic               rx_valid;
  logic [7:0]         rx_data;
  logic               q_zero;
  logic [WIDTH-1:0]   limit;
  logic [CH_BITS-1:0] ch;
  logic               load;
  logic               en;
  logic               busy;
  logic               done;
  logic               aborted;
  logic               err;
  modport master (output rx_valid, rx_data, q_zero,
                  input limit, ch, load, en, busy, done, aborted, err);
  modport slave  (input rx_valid, rx_data, q_zero,
                  output limit, ch, load, en, busy, done, aborted, err);
endinterface

// File: rtl/cmd_byte_shift.sv
// cmd_byte_shift: MSB-first shadow limit shift register plus frame XOR accumulator (PHOTONIC_CMD_CHECKSUM_EN)
module cmd_byte_shift #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             shift,
`ifdef PHOTONIC_CMD_CHECKSUM_EN
  input  logic             acc,
  output logic [7:0]       chk,
`endif
  input  logic [7:0]       din,
  output logic [WIDTH-1:0] nxt
);
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH+7:0] cat;
  assign cat = {sh_q, din};
  assign nxt = sh_d;
  // next shadow value: cleared on a new frame, new byte enters at the LSB end
  always_comb sh_d = clr ? '0 : shift ? cat[WIDTH-1:0] : sh_q;
  // shadow limit register
  always_ff @(posedge clk) sh_q <= reset ? '0 : sh_d;
`ifdef PHOTONIC_CMD_CHECKSUM_EN
  logic [7:0] x_q, x_d;
  assign chk = x_q;
  // running XOR of CMD and limit bytes
  always_comb x_d = clr ? '0 : acc ? x_q ^ din : x_q;
  // checksum accumulator register
  always_ff @(posedge clk) x_q <= reset ? '0 : x_d;
`endif
endmodule

// File: rtl/photonic_cmd_decoder.sv
// photonic_cmd_decoder: framed command parser driving the switch down-counter; PHOTONIC_CMD_CHECKSUM_EN adds the CHK byte
module photonic_cmd_decoder
  import photonic_cmd_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int CH_BITS = 2
) (
  input logic                  clk,
  input logic                  reset,
  photonic_cmd_decoder_if.slave bus
);
  localparam int NB = WIDTH / 8;
  localparam int CW = cnt_bits(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(NB - 1);
`ifdef PHOTONIC_CMD_CHECKSUM_EN
  localparam state_t AFTER_DATA = CHK;
`else
  localparam state_t AFTER_DATA = LOAD;
`endif
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CH_BITS-1:0] ch_sh_q, ch_sh_d, ch_q, ch_d;
  logic [WIDTH-1:0] limit_q, limit_d, sh_nxt;
  logic load_q, load_d, en_q, en_d, busy_q, busy_d;
  logic done_q, done_d, ab_q, ab_d;
  logic rx_sync, rx_abort, clr, shift;
  assign rx_sync  = bus.rx_valid && bus.rx_data == SYNC_BYTE;
  assign rx_abort = bus.rx_valid && bus.rx_data == ABORT_BYTE;
  assign clr      = state_q == IDLE && rx_sync;
  assign shift    = state_q == DATA && bus.rx_valid;
`ifdef PHOTONIC_CMD_CHECKSUM_EN
  logic acc, err_q, err_d;
  logic [7:0] chk;
  assign acc = bus.rx_valid && (state_q == CMD || state_q == DATA);
`endif
  cmd_byte_shift #(.WIDTH(WIDTH)) u_shift (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .shift (shift),
`ifdef PHOTONIC_CMD_CHECKSUM_EN
    .acc   (acc),
    .chk   (chk),
`endif
    .din   (bus.rx_data),
    .nxt   (sh_nxt)
  );
  // frame parsing and run control; limit/ch commit on the edge entering LOAD
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_sh_d = ch_sh_q;
    done_d  = 1'b0;
    ab_d    = 1'b0;
`ifdef PHOTONIC_CMD_CHECKSUM_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: state_d = rx_sync ? CMD : IDLE;
      CMD: if (bus.rx_valid) begin
        ch_sh_d = bus.rx_data[CH_BITS-1:0];
        cnt_d   = '0;
        state_d = DATA;
      end
      DATA: if (bus.rx_valid) begin
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == LAST) ? AFTER_DATA : DATA;
      end
`ifdef PHOTONIC_CMD_CHECKSUM_EN
      CHK: if (bus.rx_valid) begin
        err_d   = chk != bus.rx_data;
        state_d = err_d ? IDLE : LOAD;
      end
`endif
      LOAD: state_d = RUN;
      RUN: begin
        done_d  = bus.q_zero;
        ab_d    = !bus.q_zero && rx_abort;
        state_d = (done_d || ab_d) ? IDLE : RUN;
      end
      default: state_d = IDLE;
    endcase
    limit_d = (state_d == LOAD) ? sh_nxt : limit_q;
    ch_d    = (state_d == LOAD) ? ch_sh_q : ch_q;
    load_d  = state_d == LOAD;
    en_d    = state_d == RUN;
    busy_d  = state_d != IDLE;
  end
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ch_sh_q <= '0;
      ch_q    <= '0;
      limit_q <= '0;
      load_q  <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ab_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_sh_q <= ch_sh_d;
      ch_q    <= ch_d;
      limit_q <= limit_d;
      load_q  <= load_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ab_q    <= ab_d;
    end
  end
`ifdef PHOTONIC_CMD_CHECKSUM_EN
  // checksum failure pulse
  always_ff @(posedge clk) err_q <= reset ? 1'b0 : err_d;
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif
  assign bus.limit   = limit_q;
  assign bus.ch      = ch_q;
  assign bus.load    = load_q;
  assign bus.en      = en_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.aborted = ab_q;
endmodule

// File: tb/tb_photonic_cmd_decoder.sv
// tb_photonic_cmd_decoder: frame-level reference model plus counter model, directed and random command traffic
module tb_photonic_cmd_decoder;
  localparam int WIDTH = 16;
  localparam int CH_BITS = 2;
  localparam int NB = WIDTH / 8;
`ifdef PHOTONIC_CMD_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  localparam int FL = NB + 1 + CK;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  photonic_cmd_decoder_if #(.WIDTH(WIDTH), .CH_BITS(CH_BITS)) bus ();
  photonic_cmd_decoder #(.WIDTH(WIDTH), .CH_BITS(CH_BITS)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // downstream down-counter stand-in
  logic [WIDTH-1:0] cnt_m;
  always @(posedge clk)
    if (reset) cnt_m <= '0;
    else if (bus.load) cnt_m <= bus.limit;
    else if (bus.en && cnt_m != 0) cnt_m <= cnt_m - 1'b1;
  assign bus.q_zero = (cnt_m == 0);

  // frame-level reference: 0 idle, 1 collecting frame bytes, 2 load cycle, 3 running
  int ph = 0;
  logic [7:0] fb[$];
  logic [7:0] xs, b0;
  logic [WIDTH-1:0] lv;
  logic [WIDTH-1:0] e_limit;
  logic [CH_BITS-1:0] e_ch;
  logic e_load, e_en, e_busy, e_done, e_ab, e_err;
  always @(posedge clk) begin
    e_done = 1'b0;
    e_ab = 1'b0;
    e_err = 1'b0;
    if (reset) begin
      ph = 0;
      fb.delete();
      e_limit = '0;
      e_ch = '0;
    end else if (ph == 0) begin
      if (bus.rx_valid && bus.rx_data == 8'hA5) begin
        ph = 1;
        fb.delete();
      end
    end else if (ph == 1) begin
      if (bus.rx_valid) begin
        fb.push_back(bus.rx_data);
        if (fb.size() == FL) begin
          xs = '0;
          lv = '0;
          for (int i = 0; i <= NB; i++) xs ^= fb[i];
          for (int i = 1; i <= NB; i++) lv = (lv << 8) | WIDTH'(fb[i]);
          if (CK == 1 && xs != fb[FL-1]) begin
            e_err = 1'b1;
            ph = 0;
          end else begin
            b0 = fb[0];
            e_limit = lv;
            e_ch = b0[CH_BITS-1:0];
            ph = 2;
          end
        end
      end
    end else if (ph == 2) ph = 3;
    else if (bus.q_zero) begin
      e_done = 1'b1;
      ph = 0;
    end else if (bus.rx_valid && bus.rx_data == 8'h5A) begin
      e_ab = 1'b1;
      ph = 0;
    end
    e_load = (ph == 2);
    e_en = (ph == 3);
    e_busy = (ph != 0);
  end

  // every-cycle comparison against the reference
  always @(negedge clk)
    if (chk_on) begin
      check("limit", bus.limit, e_limit);
      check("ch", bus.ch, e_ch);
      check("load", bus.load, e_load);
      check("en", bus.en, e_en);
      check("busy", bus.busy, e_busy);
      check("done", bus.done, e_done);
      check("aborted", bus.aborted, e_ab);
      check("err", bus.err, e_err);
      check("load_en_excl", bus.load & bus.en, 0);
    end

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [WIDTH-1:0] lim, input bit bad);
    logic [7:0] x = cmd;
    logic [7:0] b;
    send_byte(8'hA5);
    send_byte(cmd);
    for (int i = NB - 1; i >= 0; i--) begin
      b = lim[i*8 +: 8];
      x ^= b;
      send_byte(b);
    end
    if (CK == 1) send_byte(bad ? ~x : x);
  endtask

  task automatic run_len(input int bound, output int n_en, output bit got_done);
    n_en = 0;
    got_done = 1'b0;
    for (int i = 0; i < bound && !got_done; i++) begin
      @(negedge clk);
      if (bus.en) n_en++;
      if (bus.done) got_done = 1'b1;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", bus.busy, 0);
  endtask

  int n_en;
  bit got_done;
  int r;
  logic [7:0] jb;
  logic [WIDTH-1:0] lim;

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    @(negedge clk);
    chk_on = 1'b1;
    @(negedge clk);
    check("rst_limit", bus.limit, 0);
    check("rst_en", bus.en, 0);
    check("rst_busy", bus.busy, 0);
    reset = 1'b0;
    @(negedge clk);

    send_frame(8'h01, 16'h0003, 1'b0);
    check("t1_load", bus.load, 1);
    check("t1_limit", bus.limit, 16'h0003);
    check("t1_ch", bus.ch, 1);
    run_len(50, n_en, got_done);
    check("t1_en_cycles", n_en, 4);
    check("t1_done", got_done, 1);
    @(negedge clk);

`ifdef PHOTONIC_CMD_CHECKSUM_EN
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h05);
    send_byte(8'hFF);
    check("t2_err", bus.err, 1);
    check("t2_load", bus.load, 0);
    check("t2_limit_kept", bus.limit, 16'h0003);
    @(negedge clk);
`endif

    send_frame(8'h02, 16'h0000, 1'b0);
    check("t3_load", bus.load, 1);
    check("t3_ch", bus.ch, 2);
    run_len(20, n_en, got_done);
    check("t3_en_cycles", n_en, 1);
    check("t3_done", got_done, 1);
    @(negedge clk);

    send_frame(8'h00, 16'h0100, 1'b0);
    check("t4_limit", bus.limit, 16'h0100);
    repeat (10) @(negedge clk);
    check("t4_en_run10", bus.en, 1);
    send_byte(8'h5A);
    check("t4_en_off", bus.en, 0);
    check("t4_aborted", bus.aborted, 1);
    check("t4_no_done", bus.done, 0);
    repeat (5) @(negedge clk);
    check("t4_idle", bus.busy, 0);

    send_byte(8'h11);
    send_byte(8'h22);
    check("t5_noise_busy", bus.busy, 0);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    check("t5_midframe_busy", bus.busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5_rst_limit", bus.limit, 0);
    check("t5_rst_busy", bus.busy, 0);
    check("t5_rst_ch", bus.ch, 0);
    send_frame(8'h03, 16'h1234, 1'b0);
    check("t6_load", bus.load, 1);
    check("t6_limit", bus.limit, 16'h1234);
    check("t6_ch", bus.ch, 3);
    run_len(6000, n_en, got_done);
    check("t6_en_cycles", n_en, 32'h1235);
    check("t6_done", got_done, 1);

    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 9);
      if (r < 4) begin
        wait_idle();
        lim = ($urandom_range(0, 7) == 0) ? 16'h00A5 : WIDTH'($urandom_range(0, 40));
        send_frame(8'($urandom), lim, $urandom_range(0, 5) == 0);
      end else if (r < 7) begin
        jb = 8'($urandom);
        if (jb == 8'hA5) jb = 8'h5A;
        send_byte(jb);
      end else if (r < 9) begin
        repeat ($urandom_range(1, 30)) @(negedge clk);
      end else begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    end
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
